tl_ram_device: RTL

TileLink-UH device endpoint terminating the A/D channel pair with a single-ported, word-addressed on-chip RAM. It is the responder at the far end of a TileLink link: it accepts requests from an upstream host, optionally through register slices, and returns grant-channel responses. Get and Put bursts are supported, and one transaction is in flight at a time. It serves as boot/scratch memory and as a bench target for the interconnect.

---
 rtl/tl_ram_device_if.sv | 55 +++++
 rtl/tl_ram_device.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_device_if.sv
// tl_ram_device_if
//   TileLink-UH A/D channel pair between an upstream host and a device.
//   master modport : host side (drives A, accepts D)
//   slave modport  : device side (accepts A, drives D)
//   A channel : host_a_valid/ready, opcode, param, size, source, address,
//               mask, corrupt, data
//   D channel : host_d_valid/ready, opcode, param, size, source, sink,
//               denied, corrupt, data
interface tl_ram_device_if #(
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned AddrWidth   = 56,
   parameter int unsigned SourceWidth = 1,
   parameter int unsigned SinkWidth   = 1,
   parameter int unsigned SizeWidth   = 3
);
   logic                     host_a_valid;
   logic                     host_a_ready;
   logic [2:0]               host_a_opcode;
   logic [2:0]               host_a_param;
   logic [SizeWidth-1:0]     host_a_size;
   logic [SourceWidth-1:0]   host_a_source;
   logic [AddrWidth-1:0]     host_a_address;
   logic [DataWidth/8-1:0]   host_a_mask;
   logic                     host_a_corrupt;
   logic [DataWidth-1:0]     host_a_data;

   logic                     host_d_valid;
   logic                     host_d_ready;
   logic [2:0]               host_d_opcode;
   logic [2:0]               host_d_param;
   logic [SizeWidth-1:0]     host_d_size;
   logic [SourceWidth-1:0]   host_d_source;
   logic [SinkWidth-1:0]     host_d_sink;
   logic                     host_d_denied;
   logic                     host_d_corrupt;
   logic [DataWidth-1:0]     host_d_data;

   modport master (
      output host_a_valid, host_a_opcode, host_a_param, host_a_size,
             host_a_source, host_a_address, host_a_mask, host_a_corrupt,
             host_a_data, host_d_ready,
      input  host_a_ready, host_d_valid, host_d_opcode, host_d_param,
             host_d_size, host_d_source, host_d_sink, host_d_denied,
             host_d_corrupt, host_d_data
   );

   modport slave (
      input  host_a_valid, host_a_opcode, host_a_param, host_a_size,
             host_a_source, host_a_address, host_a_mask, host_a_corrupt,
             host_a_data, host_d_ready,
      output host_a_ready, host_d_valid, host_d_opcode, host_d_param,
             host_d_size, host_d_source, host_d_sink, host_d_denied,
             host_d_corrupt, host_d_data
   );
endinterface

// File: rtl/tl_ram_device.sv
// tl_ram_device
//   TileLink-UH device endpoint backed by a single-ported word RAM.
//   One transaction in flight; Get/Put bursts, Intent -> HintAck,
//   Arithmetic/Logical consumed and denied, other opcodes denied.
//   Ports:
//     clk_i  : clock
//     rst_i  : synchronous active-high reset
//     host   : tl_ram_device_if.slave (A channel in, D channel out)
//   Build option:
//     TL_RAM_DEVICE_PARTIAL_EN - when defined PutPartialData writes per
//     byte mask; otherwise PutPartialData is denied and writes nothing.
module tl_ram_device #(
   parameter int unsigned          DataWidth   = 64,
   parameter int unsigned          AddrWidth   = 56,
   parameter int unsigned          SourceWidth = 1,
   parameter int unsigned          SinkWidth   = 1,
   parameter int unsigned          SizeWidth   = 3,
   parameter int unsigned          DepthWords  = 256,
   parameter logic [AddrWidth-1:0] BaseAddr    = '0
) (
   input logic            clk_i,
   input logic            rst_i,
   tl_ram_device_if.slave host
);
   localparam int unsigned LOG2B = $clog2(DataWidth / 8);
   localparam int unsigned IW    = $clog2(DepthWords);

`ifdef TL_RAM_DEVICE_PARTIAL_EN
   localparam bit PartialEn = 1'b1;
`else
   localparam bit PartialEn = 1'b0;
`endif

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic [2:0] OP_PUTF   = 3'd0;
   localparam logic [2:0] OP_PUTP   = 3'd1;
   localparam logic [2:0] OP_ARITH  = 3'd2;
   localparam logic [2:0] OP_LOGIC  = 3'd3;
   localparam logic [2:0] OP_GET    = 3'd4;
   localparam logic [2:0] OP_INTENT = 3'd5;

   localparam logic [2:0] D_ACK     = 3'd0;
   localparam logic [2:0] D_ACKDATA = 3'd1;
   localparam logic [2:0] D_HINTACK = 3'd2;

   function automatic logic [SizeWidth:0] beats_m1_f(input logic [SizeWidth-1:0] sz);
      int unsigned s = 32'(sz);
      if (s <= LOG2B) return '0;
      return (SizeWidth+1)'((32'd1 << (s - LOG2B)) - 32'd1);
   endfunction

   logic [DataWidth-1:0]   mem_q [DepthWords];

   logic [1:0]             state_q, state_d;
   logic [2:0]             op_q, op_d;
   logic [SizeWidth-1:0]   size_q, size_d;
   logic [SourceWidth-1:0] source_q, source_d;
   logic [AddrWidth-1:0]   idx_q, idx_d;
   logic [SizeWidth:0]     cnt_q, cnt_d;
   logic [SizeWidth:0]     bm1_q, bm1_d;
   logic                   denied_q, denied_d;
   logic                   d_valid_q, d_valid_d;
   logic [2:0]             d_opcode_q, d_opcode_d;
   logic                   d_denied_q, d_denied_d;
   logic                   d_corrupt_q, d_corrupt_d;
   logic [DataWidth-1:0]   d_data_q;

   logic                   a_ready, a_fire, d_fire;
   logic [AddrWidth-1:0]   widx;
   logic [AddrWidth:0]     end_w;
   logic [SizeWidth:0]     bm1_new;
   logic                   in_range;
   logic                   rd_en, rd_zero, wr_en;
   logic [IW-1:0]          rd_idx, wr_idx;
   logic                   unused_ok;

   assign unused_ok = ^{host.host_a_param, host.host_a_corrupt};

   assign a_ready = !rst_i && (state_q == ST_IDLE || state_q == ST_WRITE);
   assign a_fire  = host.host_a_valid && a_ready;
   assign d_fire  = d_valid_q && host.host_d_ready;

   // Range check is done in the word domain, with one extra bit so a burst
   // ending exactly at the top of the RAM does not overflow the compare.
   assign widx     = (host.host_a_address - BaseAddr) >> LOG2B;
   assign bm1_new  = beats_m1_f(host.host_a_size);
   assign end_w    = (AddrWidth+1)'(widx) + (AddrWidth+1)'(bm1_new) + (AddrWidth+1)'(1);
   assign in_range = (host.host_a_address >= BaseAddr) &&
                     (end_w <= (AddrWidth+1)'(DepthWords));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      size_d      = size_q;
      source_d    = source_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      bm1_d       = bm1_q;
      denied_d    = denied_q;
      d_valid_d   = d_valid_q;
      d_opcode_d  = d_opcode_q;
      d_denied_d  = d_denied_q;
      d_corrupt_d = d_corrupt_q;
      rd_en       = 1'b0;
      rd_zero     = 1'b0;
      rd_idx      = IW'(idx_q + AddrWidth'(1));
      wr_en       = 1'b0;
      wr_idx      = IW'(idx_q);
      case (state_q)
         ST_IDLE: begin
            if (a_fire) begin
               op_d     = host.host_a_opcode;
               size_d   = host.host_a_size;
               source_d = host.host_a_source;
               idx_d    = widx;
               cnt_d    = '0;
               bm1_d    = '0;
               case (host.host_a_opcode)
                  OP_GET: begin
                     bm1_d       = bm1_new;
                     state_d     = ST_RESP;
                     d_valid_d   = 1'b1;
                     d_opcode_d  = D_ACKDATA;
                     d_denied_d  = !in_range;
                     d_corrupt_d = !in_range;
                     rd_en       = 1'b1;
                     rd_idx      = IW'(widx);
                     rd_zero     = !in_range;
                  end
                  OP_PUTF, OP_PUTP: begin
                     denied_d = !in_range || (host.host_a_opcode == OP_PUTP && !PartialEn);
                     wr_en    = !denied_d;
                     wr_idx   = IW'(widx);
                     if (bm1_new == '0) begin
                        state_d     = ST_RESP;
                        d_valid_d   = 1'b1;
                        d_opcode_d  = D_ACK;
                        d_denied_d  = denied_d;
                        d_corrupt_d = 1'b0;
                     end else begin
                        state_d = ST_WRITE;
                        bm1_d   = bm1_new;
                        cnt_d   = (SizeWidth+1)'(1);
                        idx_d   = widx + AddrWidth'(1);
                     end
                  end
                  OP_ARITH, OP_LOGIC: begin
                     denied_d = 1'b1;
                     bm1_d    = bm1_new;
                     if (bm1_new == '0) begin
                        state_d     = ST_RESP;
                        d_valid_d   = 1'b1;
                        d_opcode_d  = D_ACKDATA;
                        d_denied_d  = 1'b1;
                        d_corrupt_d = 1'b1;
                        rd_en       = 1'b1;
                        rd_zero     = 1'b1;
                     end else begin
                        state_d = ST_WRITE;
                        cnt_d   = (SizeWidth+1)'(1);
                     end
                  end
                  OP_INTENT: begin
                     state_d     = ST_RESP;
                     d_valid_d   = 1'b1;
                     d_opcode_d  = D_HINTACK;
                     d_denied_d  = 1'b0;
                     d_corrupt_d = 1'b0;
                  end
                  default: begin
                     state_d     = ST_RESP;
                     d_valid_d   = 1'b1;
                     d_opcode_d  = D_ACK;
                     d_denied_d  = 1'b1;
                     d_corrupt_d = 1'b0;
                  end
               endcase
            end
         end
         ST_WRITE: begin
            if (a_fire) begin
               wr_en  = !denied_q && (op_q == OP_PUTF || op_q == OP_PUTP);
               wr_idx = IW'(idx_q);
               if (cnt_q == bm1_q) begin
                  state_d   = ST_RESP;
                  d_valid_d = 1'b1;
                  cnt_d     = '0;
                  if (op_q == OP_PUTF || op_q == OP_PUTP) begin
                     bm1_d       = '0;
                     d_opcode_d  = D_ACK;
                     d_denied_d  = denied_q;
                     d_corrupt_d = 1'b0;
                  end else begin
                     d_opcode_d  = D_ACKDATA;
                     d_denied_d  = 1'b1;
                     d_corrupt_d = 1'b1;
                     rd_en       = 1'b1;
                     rd_zero     = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + (SizeWidth+1)'(1);
                  idx_d = idx_q + AddrWidth'(1);
               end
            end
         end
         ST_RESP: begin
            // The next word is fetched only on handshake, so all D fields hold while stalled.
            if (d_fire) begin
               if (cnt_q == bm1_q) begin
                  state_d   = ST_IDLE;
                  d_valid_d = 1'b0;
               end else begin
                  cnt_d   = cnt_q + (SizeWidth+1)'(1);
                  idx_d   = idx_q + AddrWidth'(1);
                  rd_en   = 1'b1;
                  rd_zero = d_denied_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         size_q      <= '0;
         source_q    <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         bm1_q       <= '0;
         denied_q    <= 1'b0;
         d_valid_q   <= 1'b0;
         d_opcode_q  <= '0;
         d_denied_q  <= 1'b0;
         d_corrupt_q <= 1'b0;
         d_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         size_q      <= size_d;
         source_q    <= source_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         bm1_q       <= bm1_d;
         denied_q    <= denied_d;
         d_valid_q   <= d_valid_d;
         d_opcode_q  <= d_opcode_d;
         d_denied_q  <= d_denied_d;
         d_corrupt_q <= d_corrupt_d;
         if (rd_en) d_data_q <= rd_zero ? '0 : mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < DataWidth / 8; b++) begin
            if (host.host_a_mask[b]) mem_q[wr_idx][b*8 +: 8] <= host.host_a_data[b*8 +: 8];
         end
      end
   end

   assign host.host_a_ready   = a_ready;
   assign host.host_d_valid   = d_valid_q;
   assign host.host_d_opcode  = d_opcode_q;
   assign host.host_d_param   = '0;
   assign host.host_d_size    = size_q;
   assign host.host_d_source  = source_q;
   assign host.host_d_sink    = '0;
   assign host.host_d_denied  = d_denied_q;
   assign host.host_d_corrupt = d_corrupt_q;
   assign host.host_d_data    = d_data_q;
endmodule
